// File: rtl/f_d_inst_queue_pkg.sv
// Shared constants and the fetch-to-decode bundle layout for the instruction queue.
package f_d_inst_queue_pkg;

    localparam logic [31:0] OP_ERET  = 32'h4200_0018;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          FD_W     = 32 + 32 + 1 + 32 + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
        logic [31:0] badvaddr;
        logic        eret;
    } fd_bundle_t;

endpackage

// File: rtl/f_d_inst_queue_ram.sv
// Bundle storage for the fetch/decode queue: one write port, asynchronous read
// so the head entry falls through to decode without an extra cycle.
module fd_queue_ram
    import f_d_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [FD_W-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [FD_W-1:0] rdata_o
);

    logic [FD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/f_d_inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO with first-word fall-through,
// sealing after an AdEL or eret fetch until the pipeline is flushed.
module f_d_inst_queue
    import f_d_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    input  logic        f_adel,
    input  logic [31:0] f_badvaddr,
    input  logic        f_eret,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_adel,
    output logic [31:0] d_badvaddr,
    output logic        d_eret,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          sealed_q, sealed_d;
    logic          push, pop;
    fd_bundle_t    wr_bundle, rd_bundle;
    logic [FD_W-1:0] rd_raw;

    // f_ready depends only on registered state and flush, never on d_ready.
    assign f_ready = (count_q != FULL_CNT) & ~sealed_q & ~flush;
    assign d_valid = (count_q != '0);
    assign push    = f_valid & f_ready;
    assign pop     = d_valid & d_ready;
    assign count   = count_q;

    always_comb begin
        wr_bundle.pc       = f_pc;
        wr_bundle.instr    = f_adel ? 32'h0 : f_instr;
        wr_bundle.adel     = f_adel;
        wr_bundle.badvaddr = f_badvaddr;
        wr_bundle.eret     = f_eret;
    end

    fd_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push & ~rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_bundle),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_raw)
    );

    assign rd_bundle = rd_raw;

    // Stale storage is masked so an empty queue presents an all-zero (nop) head.
    assign d_pc       = d_valid ? rd_bundle.pc       : 32'h0;
    assign d_instr    = d_valid ? rd_bundle.instr    : 32'h0;
    assign d_adel     = d_valid & rd_bundle.adel;
    assign d_badvaddr = d_valid ? rd_bundle.badvaddr : 32'h0;
    assign d_eret     = d_valid & rd_bundle.eret;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        sealed_d = sealed_q;
        if (rst | flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            sealed_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (f_adel | f_eret) begin
                    sealed_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        sealed_q <= sealed_d;
    end

endmodule

// File: tb/tb_f_d_inst_queue.sv
// Scenario bench for the fetch/decode queue: a bundle scoreboard tracks what
// should be queued, and each scenario task compares the DUT head against it.
module tb_f_d_inst_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        f_valid = 1'b0;
    logic        f_adel = 1'b0;
    logic        f_eret = 1'b0;
    logic        d_ready = 1'b0;
    logic [31:0] f_pc = 32'h0;
    logic [31:0] f_instr = 32'h0;
    logic [31:0] f_badvaddr = 32'h0;
    logic        f_ready, d_valid, d_adel, d_eret;
    logic [31:0] d_pc, d_instr, d_badvaddr;
    logic [AW:0] count;
    logic [98:0] obs_head;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] bad;
        logic        adel;
        logic        eret;
    } ent_t;

    ent_t sb[$];
    bit   m_sealed;
    int   n_checks;
    int   n_fail;
    int   obs_pops;

    f_d_inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .f_valid    (f_valid),
        .f_ready    (f_ready),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .f_adel     (f_adel),
        .f_badvaddr (f_badvaddr),
        .f_eret     (f_eret),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_adel     (d_adel),
        .d_badvaddr (d_badvaddr),
        .d_eret     (d_eret),
        .count      (count)
    );

    always #5 clk = ~clk;

    assign obs_head = {d_valid, d_pc, d_instr, d_adel, d_badvaddr, d_eret};

    function automatic logic [98:0] exp_head();
        if (sb.size() == 0) return '0;
        return {1'b1, sb[0].pc, sb[0].instr, sb[0].adel, sb[0].bad, sb[0].eret};
    endfunction

    function automatic logic [AW:0] exp_cnt();
        return (AW + 1)'(sb.size());
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic adel, input logic [31:0] bad, input logic eret);
        f_valid    = v;
        f_pc       = pc;
        f_instr    = instr;
        f_adel     = adel;
        f_badvaddr = bad;
        f_eret     = eret;
    endtask

    // Update the scoreboard from the inputs presented this cycle, then clock.
    task automatic advance();
        bit   exp_fr;
        ent_t e;
        exp_fr = (sb.size() != DEPTH) && !m_sealed && !flush;
        if (d_valid === 1'b1 && d_ready) obs_pops++;
        if (rst || flush) begin
            sb.delete();
            m_sealed = 1'b0;
        end else begin
            if (sb.size() != 0 && d_ready) void'(sb.pop_front());
            if (f_valid && exp_fr) begin
                e.pc    = f_pc;
                e.instr = f_adel ? 32'h0 : f_instr;
                e.bad   = f_badvaddr;
                e.adel  = f_adel;
                e.eret  = f_eret;
                sb.push_back(e);
                if (f_adel || f_eret) m_sealed = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs_head !== 99'h0) begin
            n_fail++; $display("FAIL reset_head: got %h, want 0", obs_head);
        end
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d, want 0", count);
        end
        n_checks++;
        if (f_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_f_ready: got %b, want 1", f_ready);
        end
    endtask

    task automatic test_fill_drain();
        d_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h8000_0000 + 32'(4 * i), 32'h2400_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
            #1;
            n_checks++;
            if (f_ready !== 1'b1) begin
                n_fail++; $display("FAIL fill_f_ready[%0d]: got %b, want 1", i, f_ready);
            end
            advance();
        end
        f_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd4 || f_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_state: count %0d f_ready %b, want 4 0", count, f_ready);
        end
        d_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_checks++;
            if (d_pc !== 32'h8000_0000 + 32'(4 * i) || obs_head !== exp_head()) begin
                n_fail++; $display("FAIL drain_head[%0d]: got %h, want %h", i, obs_head, exp_head());
            end
            advance();
        end
        d_ready = 1'b0;
        #1;
        n_checks++;
        if (d_valid !== 1'b0 || f_ready !== 1'b1 || count !== 3'd0) begin
            n_fail++; $display("FAIL drained: d_valid %b f_ready %b count %0d, want 0 1 0", d_valid, f_ready, count);
        end
    endtask

    task automatic test_stream();
        logic [31:0] prev_pc;
        int          start_pops;
        prev_pc    = 32'h0;
        start_pops = obs_pops;
        d_ready    = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            drive(1'b1, 32'h8000_1000 + 32'(4 * i), 32'h0000_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
            #1;
            if (i > 0) begin
                n_checks++;
                if (d_pc !== prev_pc || count !== 3'd1 || obs_head !== exp_head()) begin
                    n_fail++; $display("FAIL stream[%0d]: d_pc %h count %0d, want %h 1", i, d_pc, count, prev_pc);
                end
            end
            prev_pc = f_pc;
            advance();
        end
        f_valid = 1'b0;
        #1;
        n_checks++;
        if (d_pc !== prev_pc) begin
            n_fail++; $display("FAIL stream_last: d_pc %h, want %h", d_pc, prev_pc);
        end
        advance();
        n_checks++;
        if (obs_pops - start_pops != DEPTH + 3 || d_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_pops: got %0d d_valid %b, want %0d 0", obs_pops - start_pops, d_valid, DEPTH + 3);
        end
        d_ready = 1'b0;
    endtask

    task automatic test_adel_seal();
        d_ready = 1'b0;
        drive(1'b1, 32'h8000_0002, 32'h1234_5678, 1'b1, 32'h8000_0002, 1'b0);
        advance();
        drive(1'b1, 32'h8000_0006, 32'h2400_0001, 1'b0, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (d_instr !== 32'h0 || d_badvaddr !== 32'h8000_0002 || d_adel !== 1'b1 || obs_head !== exp_head()) begin
            n_fail++; $display("FAIL adel_head: instr %h bad %h adel %b, want 0 80000002 1", d_instr, d_badvaddr, d_adel);
        end
        n_checks++;
        if (f_ready !== 1'b0) begin
            n_fail++; $display("FAIL adel_sealed: f_ready %b, want 0", f_ready);
        end
        advance();
        advance();
        n_checks++;
        if (count !== 3'd1) begin
            n_fail++; $display("FAIL adel_no_push: count %0d, want 1", count);
        end
        f_valid = 1'b0;
        flush   = 1'b1;
        advance();
        flush = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || f_ready !== 1'b1) begin
            n_fail++; $display("FAIL adel_flush: count %0d f_ready %b, want 0 1", count, f_ready);
        end
    endtask

    task automatic test_eret_seal();
        d_ready = 1'b0;
        drive(1'b1, 32'h8000_0010, 32'h4200_0018, 1'b0, 32'h0, 1'b1);
        advance();
        drive(1'b1, 32'h8000_0014, 32'h2400_0002, 1'b0, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (f_ready !== 1'b0) begin
            n_fail++; $display("FAIL eret_sealed: f_ready %b, want 0", f_ready);
        end
        advance();
        f_pc = 32'h8000_0018;
        advance();
        f_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd1 || d_eret !== 1'b1 || obs_head !== exp_head()) begin
            n_fail++; $display("FAIL eret_only: count %0d head %h, want 1 %h", count, obs_head, exp_head());
        end
        flush = 1'b1;
        advance();
        flush = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || f_ready !== 1'b1) begin
            n_fail++; $display("FAIL eret_flush: count %0d f_ready %b, want 0 1", count, f_ready);
        end
        drive(1'b1, 32'h8000_0180, 32'h3c1a_0000, 1'b0, 32'h0, 1'b0);
        advance();
        f_valid = 1'b0;
        #1;
        n_checks++;
        if (d_valid !== 1'b1 || d_pc !== 32'h8000_0180) begin
            n_fail++; $display("FAIL handler_pc: d_valid %b d_pc %h, want 1 80000180", d_valid, d_pc);
        end
        d_ready = 1'b1;
        advance();
        d_ready = 1'b0;
    endtask

    task automatic test_flush_mid();
        d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8000_2000 + 32'(4 * i), 32'h2400_0100 + 32'(i), 1'b0, 32'h0, 1'b0);
            advance();
        end
        drive(1'b1, 32'h8000_2100, 32'h2400_0200, 1'b0, 32'h0, 1'b0);
        d_ready = 1'b1;
        flush   = 1'b1;
        #1;
        n_checks++;
        if (f_ready !== 1'b0 || count !== 3'd3) begin
            n_fail++; $display("FAIL flush_cycle: f_ready %b count %0d, want 0 3", f_ready, count);
        end
        advance();
        flush   = 1'b0;
        f_valid = 1'b0;
        d_ready = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || obs_head !== 99'h0) begin
            n_fail++; $display("FAIL after_flush: count %0d head %h, want 0 0", count, obs_head);
        end
        advance();
        n_checks++;
        if (d_valid !== 1'b0 || count !== exp_cnt()) begin
            n_fail++; $display("FAIL flush_dropped: d_valid %b count %0d, want 0 0", d_valid, count);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h8000_3004;
        exp_pc[1] = 32'h8000_3008;
        exp_pc[2] = 32'h8000_300c;
        exp_pc[3] = 32'h8000_3100;
        d_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h8000_3000 + 32'(4 * i), 32'h2400_0300 + 32'(i), 1'b0, 32'h0, 1'b0);
            advance();
        end
        drive(1'b1, 32'h8000_3100, 32'h2400_0400, 1'b0, 32'h0, 1'b0);
        d_ready = 1'b1;
        #1;
        n_checks++;
        if (f_ready !== 1'b0 || d_pc !== 32'h8000_3000) begin
            n_fail++; $display("FAIL full_pop_cycle: f_ready %b d_pc %h, want 0 80003000", f_ready, d_pc);
        end
        advance();
        d_ready = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd3 || f_ready !== 1'b1 || d_pc !== 32'h8000_3004) begin
            n_fail++; $display("FAIL full_pop_after: count %0d f_ready %b d_pc %h, want 3 1 80003004", count, f_ready, d_pc);
        end
        advance();
        f_valid = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_checks++;
            if (d_pc !== exp_pc[i] || obs_head !== exp_head()) begin
                n_fail++; $display("FAIL full_drain[%0d]: d_pc %h, want %h", i, d_pc, exp_pc[i]);
            end
            advance();
        end
        d_ready = 1'b0;
        #1;
        n_checks++;
        if (d_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL full_drained: d_valid %b count %0d, want 0 0", d_valid, count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        obs_pops = 0;
        m_sealed = 1'b0;
        test_reset();
        test_fill_drain();
        test_stream();
        test_adel_seal();
        test_eret_seal();
        test_flush_mid();
        test_full_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
